// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped, write-through cache controller.
package cache_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF  = 10;
   localparam int unsigned DATA_W_DEF  = 64;
   localparam int unsigned INDEX_W_DEF = 4;

   // Half-word select encoding shared by cpu_wsel, cb_write_enable_cpu and ram_wmask
   localparam logic [1:0] WSEL_LO  = 2'b01;
   localparam logic [1:0] WSEL_HI  = 2'b10;
   localparam logic [1:0] WSEL_ALL = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      HIT_RD,
      RAM_REQ,
      RAM_WAIT,
      FILL,
      RESP
   } state_t;

   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned index_w);
      return addr_w - index_w;
   endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid bits and tags for a direct-mapped cache of one word per line.
// Combinational hit lookup, registered update on refill.
module cache_tag_store
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INDEX_W = INDEX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_addr
);

   localparam int unsigned TAG_W = tag_w(ADDR_W, INDEX_W);
   localparam int unsigned LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];

   logic [INDEX_W-1:0] lookup_idx;
   logic [TAG_W-1:0]   lookup_tag;
   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;

   assign lookup_idx = lookup_addr[INDEX_W-1:0];
   assign lookup_tag = lookup_addr[ADDR_W-1:INDEX_W];
   assign upd_idx    = upd_addr[INDEX_W-1:0];
   assign upd_tag    = upd_addr[ADDR_W-1:INDEX_W];

   assign hit = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);

   // Line allocation on refill; reset invalidates every line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int unsigned i = 0; i < LINES; i++) tags[i] <= '0;
      end else if (upd_en) begin
         valid[upd_idx] <= 1'b1;
         tags[upd_idx]  <= upd_tag;
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: CPU load/store front end, tag lookup, read-miss refill from RAM,
// write-through no-allocate stores. Define CACHE_STATS_EN to add load hit/miss counters.
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned INDEX_W = INDEX_W_DEF
) (
   input  logic              clk,
   input  logic              gen_reset_n,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_wsel,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cb_write_enable,
   output logic [1:0]        cb_write_enable_cpu,
   output logic              cb_write_enable_ram,
   output logic              cb_read_enable,
   output logic [ADDR_W-1:0] cb_adress,
   output logic [DATA_W-1:0] cb_data_in,
   input  logic [DATA_W-1:0] cb_data_out,
   output logic              ram_req_valid,
   input  logic              ram_req_ready,
   output logic              ram_we,
   output logic [1:0]        ram_wmask,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_rsp_valid,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       stat_hits,
   output logic [15:0]       stat_misses
`endif
);

   state_t            state, next;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        wsel_q;
   logic [DATA_W-1:0] din_q;
   logic              hit;
   logic              accept;

   assign accept     = cpu_req_valid && cpu_req_ready;
   assign cb_adress  = addr_q;
   assign cb_data_in = din_q;

   cache_tag_store #(
      .ADDR_W  (ADDR_W),
      .INDEX_W (INDEX_W)
   ) u_tags (
      .clk         (clk),
      .rst_n       (gen_reset_n),
      .lookup_addr (addr_q),
      .hit         (hit),
      .upd_en      (state == FILL),
      .upd_addr    (addr_q)
   );

   // State register and request capture; din_q holds store data, then fill data on a refill
   always_ff @(posedge clk or negedge gen_reset_n) begin
      if (!gen_reset_n) begin
         state  <= IDLE;
         addr_q <= '0;
         we_q   <= 1'b0;
         wsel_q <= '0;
         din_q  <= '0;
      end else begin
         state <= next;
         if (accept) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
            wsel_q <= cpu_wsel;
            if (cpu_we) din_q <= cpu_wdata;
         end
         if (state == RAM_WAIT && ram_rsp_valid) din_q <= ram_rdata;
      end
   end

   // Next-state and per-state output strobes
   always_comb begin
      next                = state;
      cpu_req_ready       = 1'b0;
      cpu_rsp_valid       = 1'b0;
      cpu_rdata           = '0;
      cb_write_enable     = 1'b0;
      cb_write_enable_cpu = '0;
      cb_write_enable_ram = 1'b0;
      cb_read_enable      = 1'b0;
      ram_req_valid       = 1'b0;
      ram_we              = 1'b0;
      ram_wmask           = '0;
      ram_addr            = '0;
      ram_wdata           = '0;
      case (state)
         IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) next = LOOKUP;
         end
         LOOKUP: begin
            if (!we_q) begin
               if (hit) begin
                  cb_read_enable = 1'b1;
                  next           = HIT_RD;
               end else begin
                  next = RAM_REQ;
               end
            end else if (wsel_q == '0) begin
               next = RESP;
            end else begin
               if (hit) begin
                  cb_write_enable     = 1'b1;
                  cb_write_enable_cpu = wsel_q;
               end
               next = RAM_REQ;
            end
         end
         HIT_RD: begin
            cpu_rsp_valid = 1'b1;
            cpu_rdata     = cb_data_out;
            next          = IDLE;
         end
         RAM_REQ: begin
            ram_req_valid = 1'b1;
            ram_we        = we_q;
            ram_addr      = addr_q;
            if (we_q) begin
               ram_wmask = wsel_q;
               ram_wdata = din_q;
            end
            if (ram_req_ready) next = we_q ? RESP : RAM_WAIT;
         end
         RAM_WAIT: begin
            if (ram_rsp_valid) next = FILL;
         end
         FILL: begin
            cb_write_enable     = 1'b1;
            cb_write_enable_ram = 1'b1;
            next                = RESP;
         end
         RESP: begin
            cpu_rsp_valid = 1'b1;
            cpu_rdata     = we_q ? '0 : din_q;
            next          = IDLE;
         end
         default: next = IDLE;
      endcase
   end

`ifdef CACHE_STATS_EN
   // Saturating load hit/miss counters, sampled at the lookup cycle
   always_ff @(posedge clk or negedge gen_reset_n) begin
      if (!gen_reset_n) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state == LOOKUP && !we_q) begin
         if (hit) begin
            if (stat_hits != '1) stat_hits <= stat_hits + 16'd1;
         end else begin
            if (stat_misses != '1) stat_misses <= stat_misses + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a cache-block model, a RAM model and a response scoreboard.
module tb_cache_ctrl;
   import cache_ctrl_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 64;
   localparam int INDEX_W = 4;

   logic              clk = 1'b0;
   logic              gen_reset_n = 1'b0;
   logic              cpu_req_valid = 1'b0;
   logic              cpu_req_ready;
   logic              cpu_we = 1'b0;
   logic [1:0]        cpu_wsel = '0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_rsp_valid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cb_write_enable;
   logic [1:0]        cb_write_enable_cpu;
   logic              cb_write_enable_ram;
   logic              cb_read_enable;
   logic [ADDR_W-1:0] cb_adress;
   logic [DATA_W-1:0] cb_data_in;
   logic [DATA_W-1:0] cb_data_out = '0;
   logic              ram_req_valid;
   logic              ram_req_ready = 1'b0;
   logic              ram_we;
   logic [1:0]        ram_wmask;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_rsp_valid = 1'b0;
   logic [DATA_W-1:0] ram_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [15:0]       stat_hits;
   logic [15:0]       stat_misses;
`endif

   cache_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .INDEX_W (INDEX_W)
   ) dut (
      .clk                 (clk),
      .gen_reset_n         (gen_reset_n),
      .cpu_req_valid       (cpu_req_valid),
      .cpu_req_ready       (cpu_req_ready),
      .cpu_we              (cpu_we),
      .cpu_wsel            (cpu_wsel),
      .cpu_addr            (cpu_addr),
      .cpu_wdata           (cpu_wdata),
      .cpu_rsp_valid       (cpu_rsp_valid),
      .cpu_rdata           (cpu_rdata),
      .cb_write_enable     (cb_write_enable),
      .cb_write_enable_cpu (cb_write_enable_cpu),
      .cb_write_enable_ram (cb_write_enable_ram),
      .cb_read_enable      (cb_read_enable),
      .cb_adress           (cb_adress),
      .cb_data_in          (cb_data_in),
      .cb_data_out         (cb_data_out),
      .ram_req_valid       (ram_req_valid),
      .ram_req_ready       (ram_req_ready),
      .ram_we              (ram_we),
      .ram_wmask           (ram_wmask),
      .ram_addr            (ram_addr),
      .ram_wdata           (ram_wdata),
      .ram_rsp_valid       (ram_rsp_valid),
      .ram_rdata           (ram_rdata)
`ifdef CACHE_STATS_EN
      ,
      .stat_hits           (stat_hits),
      .stat_misses         (stat_misses)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cache data block model: registered read, full-line fill or half-word merge
   logic [63:0] cb_mem [1024];
   always @(posedge clk) begin
      if (cb_read_enable) cb_data_out <= cb_mem[cb_adress];
      if (cb_write_enable) begin
         if (cb_write_enable_ram) cb_mem[cb_adress] <= cb_data_in;
         else begin
            if ((cb_write_enable_cpu & WSEL_LO) != 2'b00) cb_mem[cb_adress][31:0]  <= cb_data_in[31:0];
            if ((cb_write_enable_cpu & WSEL_HI) != 2'b00) cb_mem[cb_adress][63:32] <= cb_data_in[63:32];
         end
      end
   end

   // RAM model: ready one cycle after valid, read data rsp_delay cycles after handshake.
   // Not reset by gen_reset_n so a pending response arrives late after a reset.
   logic [63:0]       ram_mem [1024];
   int                rsp_delay = 2;
   logic              pend = 1'b0;
   int                cnt = 0;
   logic [ADDR_W-1:0] paddr = '0;
   always @(posedge clk) begin
      ram_rsp_valid <= 1'b0;
      ram_req_ready <= ram_req_valid && !ram_req_ready;
      if (ram_req_valid && ram_req_ready) begin
         if (ram_we) begin
            if ((ram_wmask & WSEL_LO) != 2'b00) ram_mem[ram_addr][31:0]  <= ram_wdata[31:0];
            if ((ram_wmask & WSEL_HI) != 2'b00) ram_mem[ram_addr][63:32] <= ram_wdata[63:32];
         end else begin
            pend  <= 1'b1;
            cnt   <= rsp_delay;
            paddr <= ram_addr;
         end
      end else if (pend) begin
         if (cnt == 0) begin
            ram_rsp_valid <= 1'b1;
            ram_rdata     <= ram_mem[paddr];
            pend          <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   // Scoreboard and event monitor
   typedef struct {
      bit          is_load;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   int          n_cbrd = 0, n_cbwr = 0, n_fill = 0, n_ramrd = 0, n_ramwr = 0, n_rsp = 0;
   logic [1:0]  last_wsel = '0, last_wmask = '0;
   logic [63:0] last_fill = '0, last_wdata = '0;
   logic [9:0]  last_ram_addr = '0;
   int          acc_cyc = 0, rsp_cyc = 0;

   always @(negedge clk) begin
      if (gen_reset_n) begin
         if (cb_read_enable) n_cbrd++;
         if (cb_write_enable && cb_write_enable_ram) begin
            n_fill++;
            last_fill = cb_data_in;
         end
         if (cb_write_enable && !cb_write_enable_ram) begin
            n_cbwr++;
            last_wsel = cb_write_enable_cpu;
         end
         if (ram_req_valid && ram_req_ready) begin
            last_ram_addr = ram_addr;
            if (ram_we) begin
               n_ramwr++;
               last_wmask = ram_wmask;
               last_wdata = ram_wdata;
            end else begin
               n_ramrd++;
            end
         end
         if (cpu_rsp_valid) begin
            exp_t e;
            rsp_cyc = cyc + 1;
            n_rsp++;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_rsp", {63'd0, cpu_rsp_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.is_load) check("sb_rdata", cpu_rdata, e.data);
            end
         end
      end
   end

   task automatic issue(input bit we, input logic [1:0] wsel, input logic [9:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp);
      int t = 0;
      while (!cpu_req_ready && t < 50) begin
         @(negedge clk); #1;
         t++;
      end
      if (!cpu_req_ready) check("req_ready_timeout", {63'd0, cpu_req_ready}, 64'd1);
      cpu_req_valid = 1'b1;
      cpu_we        = we;
      cpu_wsel      = wsel;
      cpu_addr      = addr;
      cpu_wdata     = wdata;
      exp_q.push_back('{is_load: !we, data: exp});
      @(posedge clk); #1;
      acc_cyc       = cyc;
      cpu_req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int start = n_rsp;
      int t = 0;
      while (n_rsp == start && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      check("rsp_timeout", {63'd0, n_rsp != start}, 64'd1);
   endtask

   task automatic do_req(input bit we, input logic [1:0] wsel, input logic [9:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp);
      issue(we, wsel, addr, wdata, exp);
      wait_rsp();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int t;
      int rsp_before, fill_before;
      for (int i = 0; i < 1024; i++) begin
         cb_mem[i]  = '0;
         ram_mem[i] = {32'h5A00_0000 + i, 32'h0000_A500 + i};
      end
      ram_mem[1] = 64'd15;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", {63'd0, cpu_req_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, cpu_rsp_valid}, 64'd0);
      check("rst_ram_req_valid", {63'd0, ram_req_valid}, 64'd0);
      check("rst_cb_we", {63'd0, cb_write_enable}, 64'd0);
      check("rst_cb_re", {63'd0, cb_read_enable}, 64'd0);
      check("rst_cb_adress", {54'd0, cb_adress}, 64'd0);
      gen_reset_n = 1'b1;
      @(negedge clk); #1;

      // Load miss with refill
      do_req(1'b0, 2'b00, 10'h001, '0, 64'd15);
      check("miss1_ram_reads", n_ramrd, 1);
      check("miss1_ram_addr", {54'd0, last_ram_addr}, 64'h001);
      check("miss1_fill_count", n_fill, 1);
      check("miss1_fill_data", last_fill, 64'd15);

      // Load hit
      do_req(1'b0, 2'b00, 10'h001, '0, 64'd15);
      check("hit_latency", rsp_cyc - acc_cyc, 2);
      check("hit_cb_reads", n_cbrd, 1);
      check("hit_no_ram", n_ramrd, 1);

      // Store hit, low half
      do_req(1'b1, WSEL_LO, 10'h001, 64'hAAAA_BBBB_CCCC_DDDD, '0);
      check("st_cb_writes", n_cbwr, 1);
      check("st_cb_wsel", {62'd0, last_wsel}, 64'h1);
      check("st_ram_writes", n_ramwr, 1);
      check("st_ram_wmask", {62'd0, last_wmask}, 64'h1);
      check("st_ram_wdata", last_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
      do_req(1'b0, 2'b00, 10'h001, '0, 64'h0000_0000_CCCC_DDDD);
      check("st_reload_no_ram", n_ramrd, 1);

      // Store with empty select: no cache or RAM activity
      do_req(1'b1, 2'b00, 10'h001, 64'hFFFF_FFFF_FFFF_FFFF, '0);
      check("wsel0_no_ram", n_ramwr, 1);
      check("wsel0_no_cb", n_cbwr, 1);

      // Store miss: RAM only, then load misses
      do_req(1'b1, WSEL_ALL, 10'h011, 64'h1111_2222_3333_4444, '0);
      check("stmiss_no_cb", n_cbwr, 1);
      check("stmiss_ram_writes", n_ramwr, 2);
      check("stmiss_ram_addr", {54'd0, last_ram_addr}, 64'h011);
      do_req(1'b0, 2'b00, 10'h011, '0, 64'h1111_2222_3333_4444);
      check("stmiss_load_miss", n_ramrd, 2);

      // Same index, different tag: each access evicts the other
      do_req(1'b0, 2'b00, 10'h001, '0, 64'h0000_0000_CCCC_DDDD);
      check("conf1_miss", n_ramrd, 3);
      do_req(1'b0, 2'b00, 10'h011, '0, 64'h1111_2222_3333_4444);
      check("conf2_miss", n_ramrd, 4);
      do_req(1'b0, 2'b00, 10'h001, '0, 64'h0000_0000_CCCC_DDDD);
      check("conf3_miss", n_ramrd, 5);
`ifdef CACHE_STATS_EN
      check("stat_hits", {48'd0, stat_hits}, 64'd2);
      check("stat_misses", {48'd0, stat_misses}, 64'd5);
`endif

      // Reset while waiting on RAM read data
      rsp_delay = 6;
      issue(1'b0, 2'b00, 10'h021, '0, '0);
      t = 0;
      while (n_ramrd == 5 && t < 50) begin
         @(negedge clk); #1;
         t++;
      end
      check("rw_handshake", n_ramrd, 6);
      @(negedge clk);
      gen_reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("rw_rst_req_ready", {63'd0, cpu_req_ready}, 64'd1);
      check("rw_rst_rsp_valid", {63'd0, cpu_rsp_valid}, 64'd0);
      check("rw_rst_cb_we", {63'd0, cb_write_enable}, 64'd0);
      check("rw_rst_ram_valid", {63'd0, ram_req_valid}, 64'd0);
      check("rw_rst_cb_adress", {54'd0, cb_adress}, 64'd0);
`ifdef CACHE_STATS_EN
      check("rw_rst_stat_misses", {48'd0, stat_misses}, 64'd0);
`endif
      rsp_before  = n_rsp;
      fill_before = n_fill;
      repeat (2) @(negedge clk);
      gen_reset_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("late_rsp_no_cpu_rsp", n_rsp, rsp_before);
      check("late_rsp_no_fill", n_fill, fill_before);
      rsp_delay = 2;
      do_req(1'b0, 2'b00, 10'h001, '0, 64'h0000_0000_CCCC_DDDD);
      check("post_rst_miss", n_ramrd, 7);
`ifdef CACHE_STATS_EN
      check("post_rst_stat_hits", {48'd0, stat_hits}, 64'd0);
      check("post_rst_stat_misses", {48'd0, stat_misses}, 64'd1);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
